// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared constants for the data-memory responder and its timer
package dmem_pkg;

  localparam logic [31:0] IO_BASE_DEFAULT = 32'hFFFF_0000;

  localparam logic [4:0] OFF_COUNT   = 5'h00;
  localparam logic [4:0] OFF_COMPARE = 5'h04;
  localparam logic [4:0] OFF_STATUS  = 5'h08;
  localparam logic [4:0] OFF_CTRL    = 5'h0C;
  localparam logic [4:0] OFF_ERRADDR = 5'h10;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_RELOAD  = 1;
  localparam int CTRL_IRQ     = 2;
  localparam int STATUS_MATCH = 0;

endpackage

// File: rtl/dmem_timer.sv
// rtl/dmem_timer.sv - memory-mapped timer: COUNT/COMPARE/STATUS/CTRL and TimerIRQ level
module dmem_timer
  import dmem_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [2:0]  wr_sel,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        match_flag,
  output logic [2:0]  ctrl,
  output logic        irq
);

  logic wr_count, wr_compare, wr_status, wr_ctrl;
  logic hit;

  assign wr_count   = wr_en && (wr_sel == OFF_COUNT[4:2]);
  assign wr_compare = wr_en && (wr_sel == OFF_COMPARE[4:2]);
  assign wr_status  = wr_en && (wr_sel == OFF_STATUS[4:2]);
  assign wr_ctrl    = wr_en && (wr_sel == OFF_CTRL[4:2]);

  // Match is only evaluated while counting; the old CTRL governs a CTRL write cycle.
  assign hit = ctrl[CTRL_EN] && (count == compare);
  assign irq = match_flag && ctrl[CTRL_IRQ];

  always_ff @(posedge clk) begin
    if (reset) begin
      count      <= '0;
      compare    <= '1;
      match_flag <= 1'b0;
      ctrl       <= '0;
    end else begin
      if (wr_count)
        count <= wdata;
      else if (ctrl[CTRL_EN])
        count <= (hit && ctrl[CTRL_RELOAD]) ? '0 : count + 32'd1;

      if (wr_compare)
        compare <= wdata;

      // A fresh match outranks a simultaneous write-1-to-clear.
      if (hit)
        match_flag <= 1'b1;
      else if (wr_status && wdata[STATUS_MATCH])
        match_flag <= 1'b0;

      if (wr_ctrl)
        ctrl <= wdata[2:0];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - word RAM plus timer peripheral behind the datapath load/store port
// Optional DMEM_ERR_EN adds the sticky MemErr output and the ERRADDR capture register.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          DEPTH   = 64,
  parameter logic [31:0] IO_BASE = IO_BASE_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
`ifdef DMEM_ERR_EN
  output logic        MemErr,
`endif
  output logic        TimerIRQ
);

  localparam int          AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [32:0] RAM_BYTES = 33'(DEPTH) * 33'd4;

  logic        ram_hit, io_hit;
  logic [2:0]  sel;
  logic [31:0] mem [DEPTH];

  logic [31:0] t_count, t_compare;
  logic        t_match;
  logic [2:0]  t_ctrl;

  assign ram_hit = {1'b0, Addr} < RAM_BYTES;
  assign io_hit  = !ram_hit && (Addr[31:5] == IO_BASE[31:5]);
  assign sel     = Addr[4:2];

  // RAM is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (MemWrite && ram_hit)
      mem[Addr[AW+1:2]] <= WriteData;
  end

  dmem_timer u_timer (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (MemWrite && io_hit),
    .wr_sel     (sel),
    .wdata      (WriteData),
    .count      (t_count),
    .compare    (t_compare),
    .match_flag (t_match),
    .ctrl       (t_ctrl),
    .irq        (TimerIRQ)
  );

`ifdef DMEM_ERR_EN
  logic        err_q;
  logic [31:0] erraddr_q;
  logic        err_hit;

  assign err_hit = (!ram_hit && !io_hit) || (io_hit && (sel > OFF_ERRADDR[4:2]));
  assign MemErr  = err_q;

  // Only the first faulting address is kept until reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_q     <= 1'b0;
      erraddr_q <= '0;
    end else if (err_hit && !err_q) begin
      err_q     <= 1'b1;
      erraddr_q <= Addr;
    end
  end
`endif

  always_comb begin
    ReadData = '0;
    if (ram_hit) begin
      ReadData = mem[Addr[AW+1:2]];
    end else if (io_hit) begin
      case (sel)
        OFF_COUNT[4:2]:   ReadData = t_count;
        OFF_COMPARE[4:2]: ReadData = t_compare;
        OFF_STATUS[4:2]:  ReadData = {31'b0, t_match};
        OFF_CTRL[4:2]:    ReadData = {29'b0, t_ctrl};
`ifdef DMEM_ERR_EN
        OFF_ERRADDR[4:2]: ReadData = erraddr_q;
`endif
        default:          ReadData = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed and randomized checks of dmem_responder against a reference model
`timescale 1ns/1ps
module tb_dmem_responder;

  localparam logic [31:0] IO      = 32'hFFFF_0000;
  localparam logic [31:0] A_COUNT = IO + 32'h00;
  localparam logic [31:0] A_CMP   = IO + 32'h04;
  localparam logic [31:0] A_STAT  = IO + 32'h08;
  localparam logic [31:0] A_CTRL  = IO + 32'h0C;
  localparam logic [31:0] A_ERR   = IO + 32'h10;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite;
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        TimerIRQ;
`ifdef DMEM_ERR_EN
  logic        MemErr;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  dmem_responder dut (
    .clk       (clk),
    .reset     (reset),
    .MemWrite  (MemWrite),
    .Addr      (Addr),
    .WriteData (WriteData),
    .ReadData  (ReadData),
`ifdef DMEM_ERR_EN
    .MemErr    (MemErr),
`endif
    .TimerIRQ  (TimerIRQ)
  );

  always #10 clk = ~clk;

  // Reference model: register values as the programmer sees them.
  logic [31:0] m_ram [64];
  bit          m_valid [64];
  logic [31:0] m_count, m_compare;
  logic        m_status;
  logic [2:0]  m_ctrl;
  logic        m_err;
  logic [31:0] m_erraddr;

  function automatic int io_off(input logic [31:0] a);
    if (a >= IO && a - IO < 32)
      return int'((a - IO) & 32'h1C);
    return -1;
  endfunction

  function automatic bit m_hit();
    return m_ctrl[0] && (m_count == m_compare);
  endfunction

  always @(posedge clk) begin
    if (MemWrite && Addr < 32'd256) begin
      m_ram[Addr[7:2]]   <= WriteData;
      m_valid[Addr[7:2]] <= 1'b1;
    end
    if (reset) begin
      m_count   <= 32'd0;
      m_compare <= 32'hFFFF_FFFF;
      m_status  <= 1'b0;
      m_ctrl    <= 3'd0;
      m_err     <= 1'b0;
      m_erraddr <= 32'd0;
    end else begin
      if (MemWrite && io_off(Addr) == 0)
        m_count <= WriteData;
      else if (m_ctrl[0])
        m_count <= (m_hit() && m_ctrl[1]) ? 32'd0 : m_count + 32'd1;
      if (MemWrite && io_off(Addr) == 4)
        m_compare <= WriteData;
      if (m_hit())
        m_status <= 1'b1;
      else if (MemWrite && io_off(Addr) == 8 && WriteData[0])
        m_status <= 1'b0;
      if (MemWrite && io_off(Addr) == 12)
        m_ctrl <= WriteData[2:0];
      if (!m_err && ((Addr >= 32'd256 && io_off(Addr) < 0) || io_off(Addr) > 16)) begin
        m_err     <= 1'b1;
        m_erraddr <= Addr;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rd_chk(input logic [31:0] a, input logic [31:0] exp, input string tag);
    MemWrite = 1'b0;
    Addr     = a;
    #1;
    chk(tag, ReadData, exp);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    MemWrite  = 1'b1;
    Addr      = a;
    WriteData = d;
    @(negedge clk);
    MemWrite  = 1'b0;
    Addr      = 32'd0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [31:0] wd;
    int          wa;
    reset = 1'b1; MemWrite = 1'b0; Addr = 32'd0; WriteData = 32'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // RAM word access, byte offset ignored
    wr(32'h4, 32'h1234_5678);
    wr(32'h8, 32'hDEAD_BEEF);
    rd_chk(32'h8, 32'hDEAD_BEEF, "ram_rd_8");
    rd_chk(32'hB, 32'hDEAD_BEEF, "ram_rd_b");
    rd_chk(32'h4, 32'h1234_5678, "ram_neighbour");

    // Unmapped accesses
`ifdef DMEM_ERR_EN
    chk("memerr_init", {31'b0, MemErr}, 32'd0);
    rd_chk(32'h8000_0000, 32'd0, "unmapped_rd");
    tick(1);
    wr(32'h9000_0000, 32'hCAFE_F00D);
    chk("memerr_set", {31'b0, MemErr}, 32'd1);
    rd_chk(A_ERR, 32'h8000_0000, "erraddr_first");
    rd_chk(32'h8, 32'hDEAD_BEEF, "ram_after_err");
    do_reset();
    chk("memerr_reset", {31'b0, MemErr}, 32'd0);
    rd_chk(A_ERR, 32'd0, "erraddr_reset");
`else
    rd_chk(32'h8000_0000, 32'd0, "unmapped_rd");
    tick(1);
    wr(32'h9000_0000, 32'hCAFE_F00D);
    rd_chk(32'h8, 32'hDEAD_BEEF, "ram_after_unmapped_wr");
    rd_chk(A_ERR, 32'd0, "erraddr_absent");
`endif
    rd_chk(IO + 32'h14, 32'd0, "io_hole_rd");
    tick(1);

    // Reset values
    do_reset();
    rd_chk(A_COUNT, 32'd0, "rst_count");
    rd_chk(A_CMP, 32'hFFFF_FFFF, "rst_compare");
    rd_chk(A_STAT, 32'd0, "rst_status");
    rd_chk(A_CTRL, 32'd0, "rst_ctrl");
    chk("rst_irq", {31'b0, TimerIRQ}, 32'd0);
    tick(10);
    rd_chk(A_COUNT, 32'd0, "count_idle");

    // Auto-reload with interrupt
    wr(A_CMP, 32'd5);
    wr(A_CTRL, 32'h7);
    for (int i = 0; i < 8; i++) begin
      rd_chk(A_COUNT, (i < 6) ? i : i - 6, "reload_count");
      rd_chk(A_STAT, (i >= 6) ? 32'd1 : 32'd0, "reload_status");
      chk("reload_irq", {31'b0, TimerIRQ}, (i >= 6) ? 32'd1 : 32'd0);
      tick(1);
    end

    // Sticky match and write-1-to-clear
    wr(A_CTRL, 32'd0);
    wr(A_STAT, 32'd1);
    wr(A_COUNT, 32'd0);
    wr(A_CMP, 32'd3);
    wr(A_CTRL, 32'd1);
    for (int i = 0; i < 6; i++) begin
      rd_chk(A_COUNT, i, "norel_count");
      tick(1);
    end
    rd_chk(A_STAT, 32'd1, "norel_status_set");
    chk("norel_irq_off", {31'b0, TimerIRQ}, 32'd0);
    wr(A_STAT, 32'd1);
    rd_chk(A_STAT, 32'd0, "w1c_clear");
    wr(A_COUNT, 32'd3);
    wr(A_STAT, 32'd1);
    rd_chk(A_STAT, 32'd1, "w1c_vs_match");
    rd_chk(A_COUNT, 32'd4, "count_after_match");

    // Wrap without flag; software write beats increment
    wr(A_CTRL, 32'd0);
    wr(A_STAT, 32'd1);
    wr(A_CMP, 32'd100);
    wr(A_COUNT, 32'hFFFF_FFFE);
    wr(A_CTRL, 32'd1);
    rd_chk(A_COUNT, 32'hFFFF_FFFE, "wrap_0");
    tick(1);
    rd_chk(A_COUNT, 32'hFFFF_FFFF, "wrap_1");
    tick(1);
    rd_chk(A_COUNT, 32'd0, "wrap_2");
    tick(1);
    rd_chk(A_COUNT, 32'd1, "wrap_3");
    rd_chk(A_STAT, 32'd0, "wrap_no_flag");
    wr(A_COUNT, 32'd7);
    rd_chk(A_COUNT, 32'd7, "count_wr_wins");

    // Randomized RAM traffic
    for (int k = 0; k < 12; k++) begin
      wa = int'($urandom_range(0, 63));
      wd = $urandom;
      wr(32'(wa * 4) + $urandom_range(0, 3), wd);
      rd_chk(32'(wa * 4) + $urandom_range(0, 3), wd, "rnd_ram_wr");
      wa = int'($urandom_range(0, 63));
      if (m_valid[wa])
        rd_chk(32'(wa * 4), m_ram[wa], "rnd_ram_old");
    end

    // Randomized timer configurations against the model
    for (int r = 0; r < 5; r++) begin
      wr(A_CTRL, 32'd0);
      wr(A_STAT, 32'd1);
      wr(A_CMP, $urandom_range(2, 12));
      wr(A_COUNT, $urandom_range(0, 5));
      wr(A_CTRL, $urandom_range(0, 7));
      for (int c = 0; c < 16; c++) begin
        rd_chk(A_COUNT, m_count, "rnd_count");
        rd_chk(A_STAT, {31'b0, m_status}, "rnd_status");
        chk("rnd_irq", {31'b0, TimerIRQ}, {31'b0, m_status & m_ctrl[2]});
        if ($urandom_range(0, 5) == 0)
          wr(A_STAT, 32'd1);
        else
          tick(1);
      end
    end
`ifdef DMEM_ERR_EN
    chk("rnd_memerr", {31'b0, MemErr}, {31'b0, m_err});
    rd_chk(A_ERR, m_erraddr, "rnd_erraddr");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
